// File: rtl/tribus_pkg.sv
// Shared types and width helpers for the tri-state bus arbiter.
package tribus_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StTurn
    } state_e;

    // Counter/index width that never collapses to zero bits.
    function automatic int unsigned min1_clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tribus_rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last winner.
module rr_arbiter
    import tribus_pkg::*;
#(
    parameter int unsigned NCH = 4,
    localparam int unsigned IDXW = min1_clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [IDXW-1:0] last,
    output logic [NCH-1:0]  winner,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    int unsigned cand;

    always_comb begin
        winner = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = 0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            cand = (int'(last) + k) % NCH;
            if (!any && req[cand]) begin
                any          = 1'b1;
                idx          = IDXW'(cand);
                winner[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tribus_arbiter.sv
// N-channel tri-state bus driver: round-robin grant per burst, hi-Z turnaround between owners.
module tribus_arbiter
    import tribus_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned NCH      = 4,
    parameter int unsigned MAXBURST = 4,
    parameter int unsigned TURN     = 1,
    localparam int unsigned IDXW    = min1_clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       req,
    input  logic [NCH*WIDTH-1:0] din,
    inout  wire  [WIDTH-1:0]     bus,
    output logic [NCH-1:0]       gnt,
    output logic [IDXW-1:0]      owner,
    output logic                 oe,
    output logic                 valid
);

    localparam int unsigned CNTW  = min1_clog2(MAXBURST);
    localparam int unsigned TURNW = min1_clog2(TURN + 1);

    state_e                  state_q;
    logic [CNTW-1:0]         beat_cnt_q;
    logic [TURNW-1:0]        turn_cnt_q;
    logic [IDXW-1:0]         last_q;

    logic [NCH-1:0]          arb_winner;
    logic [IDXW-1:0]         arb_idx;
    logic                    arb_any;
    logic                    arb_now;
    logic                    burst_end;
    logic [NCH-1:0][WIDTH-1:0] din_arr;

    rr_arbiter #(
        .NCH (NCH)
    ) u_rr (
        .req    (req),
        .last   (last_q),
        .winner (arb_winner),
        .idx    (arb_idx),
        .any    (arb_any)
    );

    assign din_arr   = din;
    assign valid     = oe & req[owner];
    assign bus       = oe ? din_arr[owner] : {WIDTH{1'bz}};
    assign burst_end = (valid && beat_cnt_q == CNTW'(MAXBURST - 1)) || !req[owner];
    // Arbitration happens in IDLE and in the final turnaround cycle.
    assign arb_now   = (state_q == StIdle) ||
                       (state_q == StTurn && turn_cnt_q == TURNW'(TURN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            gnt        <= '0;
            owner      <= '0;
            oe         <= 1'b0;
            beat_cnt_q <= '0;
            turn_cnt_q <= '0;
            last_q     <= IDXW'(NCH - 1);
        end else begin
            unique case (state_q)
                StDrive: begin
                    if (burst_end) begin
                        state_q    <= StTurn;
                        gnt        <= '0;
                        oe         <= 1'b0;
                        beat_cnt_q <= '0;
                        turn_cnt_q <= '0;
                    end else if (valid) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                    end
                end
                StIdle, StTurn: begin
                    if (arb_now) begin
                        turn_cnt_q <= '0;
                        if (arb_any) begin
                            state_q    <= StDrive;
                            gnt        <= arb_winner;
                            owner      <= arb_idx;
                            oe         <= 1'b1;
                            last_q     <= arb_idx;
                            beat_cnt_q <= '0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        turn_cnt_q <= turn_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
